// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Detects data-memory wait states, EX-stage redirects and load-use hazards
// and drives the PC / IF_ID / ID_EX / EX_MEM stall and flush controls.
// A watchdog moves the controller into a FAULT state if a single memory
// access waits too long; only rst leaves FAULT.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   id_rs1, id_rs2      - source registers of the instruction in ID
//   id_uses_rs2         - ID instruction reads rs2
//   ex_rd, ex_reg_write - destination / write enable held in ID_EX
//   ex_result_sel       - ID_EX result select (2'b01 = load)
//   ex_redirect         - taken branch / jump resolved in EX
//   mem_req, mem_ready  - data-memory access in MEM and its completion
//   stall_*, flush_*    - pipeline controls (combinational)
//   mem_timeout_err     - sticky timeout flag
//   stall_cnt           - saturating count of cycles with stall_pc high
//   state               - FSM state: 00 RUN, 01 MEM_WAIT, 10 FAULT
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_sel,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             stall_id_ex,
  output logic             flush_id_ex,
  output logic             stall_ex_mem,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;

  localparam logic [7:0]       TIMEOUT = MEM_TIMEOUT[7:0];
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       r_state, w_state_nxt;
  logic [7:0]       r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_memwait, w_load_use;

  assign w_memwait  = mem_req & ~mem_ready;
  // Register x0 never carries a dependency.
  assign w_load_use = ex_reg_write & (ex_result_sel == 2'b01) & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign w_wait_inc = r_wait_cnt + 8'd1;

  // Control outputs. The cycle MEM_WAIT ends decodes like RUN so a pending
  // redirect or load-use is acted on as soon as the memory wait clears.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    if (!rst) begin
      if (r_state == ST_FAULT || w_memwait) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (w_load_use) begin
        // Hold PC and IF_ID, inject one bubble into ID_EX.
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      ST_RUN: begin
        if (w_memwait) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (w_memwait) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == TIMEOUT) begin
            w_state_nxt = ST_FAULT;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
        end
      end
      ST_FAULT: begin
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
      if (stall_pc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;
  assign state           = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Each driven cycle pushes its expected outputs into a queue; a monitor on
// the falling edge pops and compares them against the DUT.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [5:0]    ctrl;  // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem}
    logic [1:0]    st;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs2, ex_reg_write, ex_redirect, mem_req, mem_ready;
  logic [1:0]    ex_result_sel;
  logic          stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    state;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Reference model state
  logic [1:0]    m_state;
  int unsigned   m_wait;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_result_sel  (ex_result_sel),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .stall_id_ex    (stall_id_ex),
    .flush_id_ex    (flush_id_ex),
    .stall_ex_mem   (stall_ex_mem),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt      (stall_cnt),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ctrl", 32'({stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
                         stall_ex_mem}), 32'(e.ctrl));
      check("state", 32'(state), 32'(e.st));
      check("err", 32'(mem_timeout_err), 32'(e.err));
      check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  // Drive one cycle: compute expectations, push, advance the model at the edge.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic rw,
                      input logic [1:0] sel, input logic redir, input logic mreq,
                      input logic mrdy);
    exp_t        e;
    logic        mw, lu;
    logic [1:0]  ns;
    int unsigned nw;
    logic        ne;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
    ex_reg_write = rw; ex_result_sel = sel; ex_redirect = redir;
    mem_req = mreq; mem_ready = mrdy;
    mw = mreq && !mrdy;
    lu = rw && sel == 2'b01 && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    if (r)                        e.ctrl = 6'b000000;
    else if (m_state == 2'b10)    e.ctrl = 6'b110101;
    else if (mw)                  e.ctrl = 6'b110101;
    else if (redir)               e.ctrl = 6'b001010;
    else if (lu)                  e.ctrl = 6'b110010;
    else                          e.ctrl = 6'b000000;
    e.st = m_state; e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    ns = m_state; nw = m_wait; ne = m_err;
    if (m_state == 2'b00 && mw) begin
      ns = 2'b01; nw = 1;
    end else if (m_state == 2'b01) begin
      if (!mw) begin
        ns = 2'b00; nw = 0;
      end else if (m_wait + 1 == TO) begin
        ns = 2'b10; ne = 1'b1; nw = m_wait + 1;
      end else begin
        nw = m_wait + 1;
      end
    end
    @(posedge clk);
    if (r) begin
      m_state = 2'b00; m_wait = 0; m_err = 1'b0; m_cnt = '0;
    end else begin
      m_state = ns; m_wait = nw; m_err = ne;
      if (e.ctrl[5] && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_result_sel = '0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    m_state = 2'b00; m_wait = 0; m_err = 1'b0; m_cnt = '0;

    idle(1'b1);
    idle(1'b0);
    // Load-use on rs1: single bubble, counter 0 -> 1
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    // Load-use on rs2, then rs2 match with id_uses_rs2 low (no hazard)
    step(1'b0, 5'd4, 5'd9, 1'b1, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd4, 5'd9, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    // Non-load result and no reg_write: no hazard
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    // Redirect beats load-use
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check("redir_cnt", 32'(stall_cnt), 32'd2);
    // x0 destination never hazards
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);

    // Memory wait: 3 cycles then ready
    idle(1'b1);
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    check("mw_state", 32'(state), 32'd1);
    for (int i = 0; i < 2; i++) step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    check("mw_done_state", 32'(state), 32'd0);
    check("mw_cnt", 32'(stall_cnt), 32'd3);
    // Memwait beats redirect; redirect acted on in the exit cycle
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);

    // Timeout: FAULT after MEM_TIMEOUT wait cycles, inputs then ignored
    idle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("to_state", 32'(state), 32'd2);
    check("to_err", 32'(mem_timeout_err), 32'd1);
    step(1'b0, 5'd5, 5'd7, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_err", 32'(mem_timeout_err), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    // Saturation: 20 stalled cycles on a 4-bit counter
    for (int i = 0; i < 20; i++)
      step(1'b0, 5'd6, 5'd7, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    check("sat_cnt", 32'(stall_cnt), 32'd15);

    // Random traffic over a small register range to hit many overlaps
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 2) != 0));

    idle(1'b0);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
